// File: rtl/bidsn_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bidsn_pkg
// Purpose  : Shared types and codes for the N-bidder auction engine
//            (FSM states, controller opcodes, bidder and controller errors).
// Revision : 1.0  initial release
// ============================================================================
package bidsn_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_ROUND    = 2'd2
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP       = 4'd0,
    OP_UNLOCK    = 4'd1,
    OP_LOCK      = 4'd2,
    OP_SEL       = 4'd3,
    OP_LOAD_BAL  = 4'd4,
    OP_SET_MASK  = 4'd5,
    OP_SET_COST  = 4'd6,
    OP_SET_TIMER = 4'd7
  } op_t;

  // Per-bidder error codes
  localparam logic [1:0] c_BERR_NONE     = 2'b00;
  localparam logic [1:0] c_BERR_DENIED   = 2'b01;  // masked, not in an open round
  localparam logic [1:0] c_BERR_FUNDS    = 2'b10;  // balance below cost + bid
  localparam logic [1:0] c_BERR_CONFLICT = 2'b11;  // bid and retract together

  // Controller error codes
  localparam logic [2:0] c_CERR_OK      = 3'b000;
  localparam logic [2:0] c_CERR_ILLEGAL = 3'b001;
  localparam logic [2:0] c_CERR_KEY     = 3'b010;
  localparam logic [2:0] c_CERR_START   = 3'b011;
  localparam logic [2:0] c_CERR_SEL     = 3'b100;
  localparam logic [2:0] c_CERR_BADOP   = 3'b101;

endpackage
`default_nettype wire

// File: rtl/bidsn_winner_sel.sv
`default_nettype none
// ============================================================================
// Module   : bidsn_winner_sel
// Purpose  : Combinational highest-bid selector. Zero bids never win; on a
//            tie the lowest index wins.
// Revision : 1.0  initial release
// ============================================================================
module bidsn_winner_sel #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic [N*W-1:0] bids,
  output logic [N-1:0]   onehot,
  output logic           valid,
  output logic [W-1:0]   amount
);

  // Strictly-greater scan from index 0 keeps the lowest index on ties
  always_comb begin
    onehot = '0;
    amount = '0;
    for (int i = 0; i < N; i++) begin
      if (bids[i*W +: W] > amount) begin
        amount    = bids[i*W +: W];
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

  assign valid = |onehot;

endmodule
`default_nettype wire

// File: rtl/bidsn_auction.sv
`default_nettype none
// ============================================================================
// Module   : bidsn_auction
// Purpose  : N-bidder sealed-round auction engine with per-bidder balances,
//            per-bid cost, key-protected configuration lock and optional
//            round timer.
// Revision : 1.0  initial release
// ============================================================================
module bidsn_auction
  import bidsn_pkg::*;
#(
  parameter int N_BIDDERS = 4,
  parameter int BID_W     = 16,
  parameter int BAL_W     = 32,
  parameter int TIMER_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [N_BIDDERS-1:0]       bid,
  input  logic [N_BIDDERS*BID_W-1:0] bid_amt,
  input  logic [N_BIDDERS-1:0]       retract,
  input  logic                       C_start,
  input  logic [3:0]                 C_op,
  input  logic [31:0]                C_data,
  output logic [N_BIDDERS-1:0]       ack,
  output logic [2*N_BIDDERS-1:0]     err,
  output logic [N_BIDDERS-1:0]       win,
  output logic [N_BIDDERS*BAL_W-1:0] balance,
  output logic                       ready,
  output logic                       roundOver,
  output logic [2:0]                 C_err,
  output logic [BAL_W-1:0]           maxBid
);

  localparam int SEL_W = (N_BIDDERS > 1) ? $clog2(N_BIDDERS) : 1;

  state_t               r_state;
  state_t               w_state_next;
  logic [31:0]          r_key;
  logic [SEL_W-1:0]     r_sel;
  logic [N_BIDDERS-1:0] r_mask;
  logic [BAL_W-1:0]     r_cost;
  logic [TIMER_W-1:0]   r_timer;
  logic [TIMER_W-1:0]   r_round_cnt;
  logic [BAL_W-1:0]     r_balance  [N_BIDDERS];
  logic [BID_W-1:0]     r_standing [N_BIDDERS];

  logic [2:0]                 w_c_err;
  logic                       w_op_exec;
  logic                       w_round_start;
  logic                       w_in_round;
  logic                       w_close;
  logic                       w_bid_window;
  logic [N_BIDDERS-1:0]       w_accept;
  logic [N_BIDDERS-1:0]       w_clear;
  logic [1:0]                 w_err  [N_BIDDERS];
  logic [BID_W-1:0]           w_amt  [N_BIDDERS];
  logic [BAL_W:0]             w_need [N_BIDDERS];
  logic [N_BIDDERS*BID_W-1:0] w_standing_flat;
  logic [N_BIDDERS-1:0]       w_win_onehot;
  logic                       w_win_valid;
  logic [BID_W-1:0]           w_win_amt;

  // A round closes when the controller drops C_start or the timer expires
  assign w_in_round   = (r_state == ST_ROUND);
  assign w_close      = w_in_round &&
                        (!C_start || ((r_timer != '0) && (r_round_cnt == r_timer)));
  assign w_bid_window = w_in_round && !w_close;

  // Per-bidder amount unpacking, affordability threshold and output packing
  for (genvar gi = 0; gi < N_BIDDERS; gi++) begin : g_bidder
    assign w_amt[gi]  = bid_amt[gi*BID_W +: BID_W];
    assign w_need[gi] = {1'b0, r_cost} + (BAL_W+1)'(w_amt[gi]);
    assign w_standing_flat[gi*BID_W +: BID_W] = r_standing[gi];
    assign balance[gi*BAL_W +: BAL_W]         = r_balance[gi];
  end

  bidsn_winner_sel #(
    .N (N_BIDDERS),
    .W (BID_W)
  ) u_winner_sel (
    .bids   (w_standing_flat),
    .onehot (w_win_onehot),
    .valid  (w_win_valid),
    .amount (w_win_amt)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= ST_UNLOCKED;
    else          r_state <= w_state_next;
  end

  // Controller decode: next state, error code and configuration-write enable
  always_comb begin
    w_state_next  = r_state;
    w_c_err       = c_CERR_OK;
    w_op_exec     = 1'b0;
    w_round_start = 1'b0;
    if (C_op > 4'd7) begin
      w_c_err = c_CERR_BADOP;
    end else begin
      case (r_state)
        ST_UNLOCKED: begin
          if (C_start)                                     w_c_err = c_CERR_START;
          else if (C_op == OP_UNLOCK)                      w_c_err = c_CERR_ILLEGAL;
          else if (C_op == OP_SEL && C_data >= 32'(N_BIDDERS)) w_c_err = c_CERR_SEL;
          else begin
            w_op_exec = (C_op != OP_NOP);
            if (C_op == OP_LOCK) w_state_next = ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          // A pending opcode takes precedence over opening a round
          if (C_op == OP_UNLOCK) begin
            if (C_data == r_key) w_state_next = ST_UNLOCKED;
            else                 w_c_err      = c_CERR_KEY;
          end else if (C_op != OP_NOP) begin
            w_c_err = c_CERR_ILLEGAL;
          end else if (C_start) begin
            w_state_next  = ST_ROUND;
            w_round_start = 1'b1;
          end
        end
        ST_ROUND: begin
          if (C_op != OP_NOP) w_c_err = c_CERR_ILLEGAL;
          if (w_close)        w_state_next = ST_LOCKED;
        end
        default: w_state_next = ST_UNLOCKED;
      endcase
    end
  end

  // Per-bidder bid/retract qualification in priority order
  always_comb begin
    w_accept = '0;
    w_clear  = '0;
    for (int i = 0; i < N_BIDDERS; i++) begin
      w_err[i] = c_BERR_NONE;
      if (w_bid_window) begin
        if (bid[i] || retract[i]) begin
          if (!r_mask[i])                          w_err[i]    = c_BERR_DENIED;
          else if (bid[i] && retract[i])           w_err[i]    = c_BERR_CONFLICT;
          else if (retract[i])                     w_clear[i]  = 1'b1;
          else if ({1'b0, r_balance[i]} < w_need[i]) w_err[i]  = c_BERR_FUNDS;
          else                                     w_accept[i] = 1'b1;
        end
      end else if (bid[i] || (w_close && retract[i])) begin
        w_err[i] = c_BERR_DENIED;
      end
    end
  end

  // Configuration registers and round counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_key       <= '0;
      r_sel       <= '0;
      r_mask      <= '1;
      r_cost      <= '0;
      r_timer     <= '0;
      r_round_cnt <= '0;
    end else begin
      if (w_op_exec) begin
        case (C_op)
          OP_LOCK:      r_key   <= C_data;
          OP_SEL:       r_sel   <= SEL_W'(C_data);
          OP_SET_MASK:  r_mask  <= C_data[N_BIDDERS-1:0];
          OP_SET_COST:  r_cost  <= BAL_W'(C_data);
          OP_SET_TIMER: r_timer <= TIMER_W'(C_data);
          default: ;
        endcase
      end
      if (w_round_start)   r_round_cnt <= '0;
      else if (w_in_round) r_round_cnt <= r_round_cnt + TIMER_W'(1);
    end
  end

  // Balances and standing bids; load, charge and settlement never coincide
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < N_BIDDERS; i++) begin
        r_balance[i]  <= '0;
        r_standing[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_BIDDERS; i++) begin
        if (w_op_exec && C_op == OP_LOAD_BAL && r_sel == SEL_W'(i))
          r_balance[i] <= BAL_W'(C_data);
        else if (w_accept[i])
          r_balance[i] <= r_balance[i] - r_cost;
        else if (w_close && w_win_onehot[i])
          r_balance[i] <= r_balance[i] - BAL_W'(w_win_amt);

        if (w_round_start)   r_standing[i] <= '0;
        else if (w_accept[i]) r_standing[i] <= w_amt[i];
        else if (w_clear[i])  r_standing[i] <= '0;
      end
    end
  end

  // Registered status pulses and round result
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack       <= '0;
      err       <= '0;
      win       <= '0;
      ready     <= 1'b0;
      roundOver <= 1'b0;
      C_err     <= '0;
      maxBid    <= '0;
    end else begin
      ack       <= w_accept;
      for (int i = 0; i < N_BIDDERS; i++) err[2*i +: 2] <= w_err[i];
      win       <= (w_close && w_win_valid) ? w_win_onehot : '0;
      ready     <= (w_state_next != ST_ROUND);
      roundOver <= w_close;
      C_err     <= w_c_err;
      if (w_round_start) maxBid <= '0;
      else if (w_close)  maxBid <= BAL_W'(w_win_amt);
    end
  end

endmodule
`default_nettype wire
